mult_booth: RTL and testbench
=============================

MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; all widths below assume WIDTH=32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a multiply, sampled on a rising clk edge.
REQ-005 SHALL have port op_a, input, 32, the signed two's-complement multiplicand.
REQ-006 SHALL have port op_b, input, 32, the signed two's-complement multiplier.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse marking that the result is valid.
REQ-009 SHALL have port hi, output, 32, the upper 32 bits of the 64-bit signed product; it feeds the HI register and the downstream write-data mux.
REQ-010 SHALL have port lo, output, 32, the lower 32 bits of the product; it feeds the LO register and the downstream write-data mux.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE or DONE with start=1 at an edge, capture M=op_a, set Q=op_b, Q_1=0, A=0 and count=WIDTH, then enter RUN.
REQ-013 SHALL use an accumulator A that is WIDTH+1 bits wide, so that A-M cannot overflow when M = -2^31.
REQ-014 SHALL, at each RUN edge, check {Q[0],Q_1} and apply: 01 -> A=A+M; 10 -> A=A-M; 00 or 11 -> no change; M is sign-extended to WIDTH+1 bits.
REQ-015 SHALL, in the same RUN edge, arithmetic-right-shift {A,Q,Q_1} by one bit with A's MSB replicated, then decrement count.
REQ-016 SHALL move from RUN to DONE on the edge that performs the WIDTH-th iteration (count 1 -> 0).
REQ-017 SHALL, on entry to DONE, load hi=A[31:0] and lo=Q.
REQ-018 SHALL give a latency of WIDTH+1 edges: start sampled at edge 0, iterations on edges 1..32, done=1 during the cycle after edge 32.
REQ-019 SHALL assert busy=1 only in RUN and done=1 only in DONE; done therefore lasts exactly one cycle.
REQ-020 SHALL move from DONE to IDLE on the next edge if start=0, or restart per REQ-012 if start=1.
REQ-021 SHALL ignore start and any changes on op_a/op_b while in RUN; operands are taken only at capture.
REQ-022 SHALL hold hi/lo stable from the DONE entry edge until the next DONE entry, including across IDLE cycles and a following RUN.
REQ-023 SHALL produce the exact 64-bit signed product for all operand pairs, including the -2^31 extremes.

Reset
REQ-024 SHALL, while reset=0, asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, A=0, Q=0, Q_1=0 and count=0.
REQ-025 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse and leave hi/lo at 0.
REQ-026 SHALL, after reset is released, ignore start until the first rising edge at which reset=1.

Verification
REQ-027 SHALL cover: op_a=3, op_b=5, start pulse at edge 0 -> busy for 32 cycles, done at edge 32, hi=0x00000000, lo=0x0000000F.
REQ-028 SHALL cover: op_a=-7 (0xFFFFFFF9), op_b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
REQ-029 SHALL cover: op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000; op_a=0x80000000, op_b=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
REQ-030 SHALL cover: start reasserted and op_a/op_b changed at edge 10 of a 3x5 run -> result still 15, done still at edge 32, no second run.
REQ-031 SHALL cover: reset=0 at edge 16 of a run -> busy=0, done=0 and hi=lo=0 immediately; a new 2x2 run after release -> lo=4 after 33 edges.
REQ-032 SHALL cover: back-to-back runs 3x5 then start held in DONE with 4x4 -> 4x4 done 33 edges after the first done; hi/lo=15 held until then, then lo=16.

Source files
------------

// File: rtl/mult_booth.sv
// Radix-2 Booth sequential signed multiplier.
// One Booth step per clock; full 2*WIDTH-bit product after WIDTH steps.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - begin a multiply (taken in IDLE or DONE)
//   op_a   - signed multiplicand
//   op_b   - signed multiplier
//   busy   - high while iterating
//   done   - one-cycle pulse, hi/lo hold the new product
//   hi, lo - upper / lower halves of the product

module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]   a_q,   a_d;
    logic [WIDTH-1:0] q_q,   q_d;
    logic             q1_q,  q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q,   m_d;
    logic [WIDTH-1:0] hi_q,  hi_d;
    logic [WIDTH-1:0] lo_q,  lo_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic             q1_sh;
    logic             capture;
    logic             last;

    // Accumulator is one bit wider than the operand so A - M
    // stays representable for the most negative multiplicand.
    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        acc = a_q;
        case ({q_q[0], q1_q})
            2'b01:   acc = a_q + m_ext;
            2'b10:   acc = a_q - m_ext;
            default: acc = a_q;
        endcase
    end

    // Arithmetic right shift of {A,Q,Q_1}; old Q_1 falls off the end.
    assign {a_sh, q_sh, q1_sh} = {acc[WIDTH], acc, q_q};

    assign capture = (state_q != RUN) && start;
    assign last    = (state_q == RUN) && (cnt_q == CW'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        q1_d  = q1_q;
        cnt_d = cnt_q;
        m_d   = m_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (capture) begin
            m_d   = op_a;
            q_d   = op_b;
            q1_d  = 1'b0;
            a_d   = '0;
            cnt_d = CW'(WIDTH);
        end else if (state_q == RUN) begin
            a_d   = a_sh;
            q_d   = q_sh;
            q1_d  = q1_sh;
            cnt_d = cnt_q - CW'(1);
            // Result registers change only when the final step lands.
            if (last) begin
                hi_d = a_sh[WIDTH-1:0];
                lo_d = q_sh;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_d;
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth.
// Products queued on issue, compared on each done pulse.

module tb_mult_booth;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    logic [63:0] sb_q[$];

    mult_booth #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                chk("product", {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Issue a start at this negedge (sampled at the next rising edge).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sb_q.push_back(prod(a, b));
    endtask

    // Count negedges until done; optional mid-run start/operand noise
    // and optional check that hi/lo keep an older value meanwhile.
    task automatic wait_done(input  bit          mess,
                             input  bit          hold,
                             input  logic [63:0] hold_v,
                             output int          cyc,
                             output int          nbusy);
        int bad;
        cyc   = 0;
        nbusy = 0;
        bad   = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            if (hold && !done && ({hi, lo} !== hold_v)) bad++;
            if (mess && cyc == 10) begin
                start = 1'b1;
                op_a  = 32'd9;
                op_b  = 32'd11;
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 60);
        if (!done) chk("timeout", 64'd0, 64'd1);
        if (hold) chk("hold", 64'(bad), 64'd0);
    endtask

    logic [31:0] ra [6];
    logic [31:0] rb [6];

    initial begin
        int cyc;
        int nb;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        // Start held during reset and release must be ignored.
        start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("no_early_run", 64'(busy), 64'd0);

        // 3 x 5
        issue(32'd3, 32'd5);
        wait_done(1'b0, 1'b0, 64'd0, cyc, nb);
        chk("lat_3x5", 64'(cyc), 64'd33);
        chk("busy_3x5", 64'(nb), 64'd32);
        chk("val_3x5", {hi, lo}, 64'h0000_0000_0000_000F);
        @(negedge clk);
        chk("idle_after", 64'({busy, done}), 64'd0);

        // -7 x 6
        issue(32'hFFFF_FFF9, 32'd6);
        wait_done(1'b0, 1'b1, 64'h0000_0000_0000_000F, cyc, nb);
        chk("val_m7x6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        // Extremes
        issue(32'h8000_0000, 32'h8000_0000);
        wait_done(1'b0, 1'b0, 64'd0, cyc, nb);
        chk("val_min_min", {hi, lo}, 64'h4000_0000_0000_0000);
        issue(32'h8000_0000, 32'h7FFF_FFFF);
        wait_done(1'b0, 1'b0, 64'd0, cyc, nb);
        chk("val_min_max", {hi, lo}, 64'hC000_0000_8000_0000);

        // Start and operands disturbed mid-run.
        @(negedge clk);
        issue(32'd3, 32'd5);
        wait_done(1'b1, 1'b0, 64'd0, cyc, nb);
        chk("lat_mess", 64'(cyc), 64'd33);
        chk("val_mess", {hi, lo}, 64'd15);
        repeat (3) @(negedge clk);
        chk("no_rerun", 64'({busy, done}), 64'd0);

        // Reset during a run: abandon, no done, hi/lo cleared.
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({busy, done}), 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(32'd2, 32'd2);
        wait_done(1'b0, 1'b1, 64'd0, cyc, nb);
        chk("lat_2x2", 64'(cyc), 64'd33);
        chk("val_2x2", {hi, lo}, 64'd4);

        // Back-to-back: start held in DONE.
        @(negedge clk);
        issue(32'd3, 32'd5);
        wait_done(1'b0, 1'b0, 64'd0, cyc, nb);
        chk("b2b_first", {hi, lo}, 64'd15);
        issue(32'd4, 32'd4);
        wait_done(1'b0, 1'b1, 64'd15, cyc, nb);
        chk("lat_b2b", 64'(cyc), 64'd33);
        chk("val_b2b", {hi, lo}, 64'd16);

        // Random and sign-mix operands.
        ra[0] = 32'hFFFF_FFFF; rb[0] = 32'hFFFF_FFFF;
        ra[1] = 32'h7FFF_FFFF; rb[1] = 32'h7FFF_FFFF;
        for (int i = 2; i < 6; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(ra[i], rb[i]);
            wait_done(1'b0, 1'b0, 64'd0, cyc, nb);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
